// File: rtl/chipbus_pkg.sv
// chipbus_slot_ctrl shared types: FSM states, slot owners,
// and the "no register" address used on the custom-register bus.
package chipbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DMA,
    OWN_CPU
  } owner_e;

  localparam logic [7:0] REG_NONE = 8'hFF;

endpackage

// File: rtl/chipbus_slot_ctrl_if.sv
// Chip bus slot interface: Agnus/CPU request side, chip RAM port,
// and custom-register return path, with master/slave views.
interface chipbus_slot_ctrl_if #(
  parameter int ADDR_W = 20
);

  logic              clk7_en;
  logic              dbr;
  logic              dbwe;
  logic [ADDR_W-1:0] dma_address;
  logic [7:0]        dma_reg_address;
  logic [15:0]       dma_wdata;

  logic              cpu_custom;
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_uds;
  logic              cpu_lds;
  logic [ADDR_W-1:0] cpu_address;
  logic [15:0]       cpu_wdata;
  logic              cpu_ack;
  logic [15:0]       cpu_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_be;
  logic [ADDR_W-1:0] mem_address;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  logic [15:0]       data_out;
  logic [7:0]        reg_address_out;
  logic              reg_strobe;
  logic              late_err;

  modport master (
    output clk7_en, dbr, dbwe,
    output dma_address, dma_reg_address, dma_wdata,
    output cpu_custom, cpu_req, cpu_we,
    output cpu_uds, cpu_lds,
    output cpu_address, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    input  mem_req, mem_we, mem_be,
    input  mem_address, mem_wdata,
    output mem_ack, mem_rdata,
    input  data_out, reg_address_out,
    input  reg_strobe, late_err
  );

  modport slave (
    input  clk7_en, dbr, dbwe,
    input  dma_address, dma_reg_address, dma_wdata,
    input  cpu_custom, cpu_req, cpu_we,
    input  cpu_uds, cpu_lds,
    input  cpu_address, cpu_wdata,
    output cpu_ack, cpu_rdata,
    output mem_req, mem_we, mem_be,
    output mem_address, mem_wdata,
    input  mem_ack, mem_rdata,
    output data_out, reg_address_out,
    output reg_strobe, late_err
  );

endinterface

// File: rtl/chipbus_wbuf.sv
// One-entry CPU write posting buffer for chipbus_slot_ctrl.
// Used only when CHIPBUS_WRITE_POST_EN is defined.
module chipbus_wbuf #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       data_i,
  input  logic [1:0]        be_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [15:0]       data_o,
  output logic [1:0]        be_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        be_q, be_d;

  // Fill on push, empty on pop; the owner never does both at once.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    if (pop_i) begin
      valid_d = 1'b0;
    end
    if (push_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
      be_d    = be_i;
    end
  end

  // Buffer storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign be_o    = be_q;

endmodule

// File: rtl/chipbus_slot_ctrl.sv
// Chip bus slot responder: one chip RAM access per 7 MHz slot.
// Optional CPU write posting: define CHIPBUS_WRITE_POST_EN.
module chipbus_slot_ctrl
  import chipbus_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int SLOT_CLKS = 4
) (
  input logic              clk,
  input logic              reset,
  chipbus_slot_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  owner_e            own_q, own_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [7:0]        reg_q, reg_d;
  logic              drain_q, drain_d;
  logic              pend_q, pend_d;
  logic [15:0]       pdata_q, pdata_d;
  logic [7:0]        preg_q, preg_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              late_q, late_d;
  logic              served_q, served_d;

  logic done;
  logic sample;
  logic acc_ack;
  logic cpu_ack;
  logic cpu_go;
  logic cap;
  logic strobe;

  assign done    = (state_q == ST_WAIT) & bus.mem_ack;
  assign sample  = bus.clk7_en &
                   ((state_q == ST_IDLE) | done);
  assign acc_ack = done & (own_q == OWN_CPU) & ~drain_q;
  assign cap     = done & (own_q == OWN_DMA) & ~we_q &
                   (reg_q != REG_NONE);
  assign strobe  = pend_q & bus.clk7_en;

`ifdef CHIPBUS_WRITE_POST_EN
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [15:0]       wb_data;
  logic [1:0]        wb_be;
  logic              wb_push;
  logic              wb_pop;
  logic              post_ack_q;
  logic              drain_go;
  logic              read_go;

  assign wb_push  = bus.cpu_req & bus.cpu_we & ~wb_valid &
                    ~served_q & ~post_ack_q;
  assign wb_pop   = done & drain_q;
  assign drain_go = bus.cpu_custom & wb_valid & ~wb_pop;
  assign read_go  = bus.cpu_custom & bus.cpu_req &
                    ~bus.cpu_we & ~wb_valid &
                    ~served_q & ~acc_ack;
  assign cpu_go   = drain_go | read_go;
  assign cpu_ack  = acc_ack | post_ack_q;

  // Posted writes are acknowledged the clk after they enter the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) post_ack_q <= 1'b0;
    else       post_ack_q <= wb_push;
  end

  chipbus_wbuf #(
    .ADDR_W (ADDR_W)
  ) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wb_push),
    .pop_i   (wb_pop),
    .addr_i  (bus.cpu_address),
    .data_i  (bus.cpu_wdata),
    .be_i    ({bus.cpu_uds, bus.cpu_lds}),
    .valid_o (wb_valid),
    .addr_o  (wb_addr),
    .data_o  (wb_data),
    .be_o    (wb_be)
  );
`else
  assign cpu_go  = bus.cpu_custom & bus.cpu_req &
                   ~served_q & ~acc_ack;
  assign cpu_ack = acc_ack;
`endif

  // Slot sampling, access sequencing and completion side effects.
  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    be_d     = be_q;
    reg_d    = reg_q;
    drain_d  = drain_q;
    pend_d   = pend_q & ~bus.clk7_en;
    pdata_d  = pdata_q;
    preg_d   = preg_q;
    rdata_d  = rdata_q;
    late_d   = late_q;
    served_d = served_q & bus.cpu_req;

    if (cpu_ack) served_d = 1'b1;

    if (cap) begin
      pend_d  = 1'b1;
      pdata_d = bus.mem_rdata;
      preg_d  = reg_q;
    end

    if (acc_ack & ~we_q) rdata_d = bus.mem_rdata;

    if (bus.clk7_en & ~sample &
        (state_q != ST_IDLE)) begin
      late_d = 1'b1;
    end

    unique case (state_q)
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (done) begin
        state_d = ST_IDLE;
        own_d   = OWN_NONE;
      end
      default: ;
    endcase

    if (sample) begin
      if (bus.dbr) begin
        state_d = ST_ISSUE;
        own_d   = OWN_DMA;
        addr_d  = bus.dma_address;
        wdata_d = bus.dma_wdata;
        we_d    = bus.dbwe;
        be_d    = 2'b11;
        reg_d   = bus.dma_reg_address;
        drain_d = 1'b0;
      end else if (cpu_go) begin
        state_d = ST_ISSUE;
        own_d   = OWN_CPU;
        reg_d   = REG_NONE;
`ifdef CHIPBUS_WRITE_POST_EN
        if (drain_go) begin
          addr_d  = wb_addr;
          wdata_d = wb_data;
          we_d    = 1'b1;
          be_d    = wb_be;
          drain_d = 1'b1;
        end else
`endif
        begin
          addr_d  = bus.cpu_address;
          wdata_d = bus.cpu_wdata;
          we_d    = bus.cpu_we;
          be_d    = {bus.cpu_uds, bus.cpu_lds};
          drain_d = 1'b0;
        end
      end
    end
  end

  // Controller state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      own_q    <= OWN_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= 2'b00;
      reg_q    <= REG_NONE;
      drain_q  <= 1'b0;
      pend_q   <= 1'b0;
      pdata_q  <= '0;
      preg_q   <= REG_NONE;
      rdata_q  <= '0;
      late_q   <= 1'b0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      be_q     <= be_d;
      reg_q    <= reg_d;
      drain_q  <= drain_d;
      pend_q   <= pend_d;
      pdata_q  <= pdata_d;
      preg_q   <= preg_d;
      rdata_q  <= rdata_d;
      late_q   <= late_d;
      served_q <= served_d;
    end
  end

  assign bus.mem_req     = (state_q == ST_ISSUE);
  assign bus.mem_we      = we_q;
  assign bus.mem_be      = be_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;

  assign bus.cpu_ack   = cpu_ack;
  assign bus.cpu_rdata = (acc_ack & ~we_q) ?
                         bus.mem_rdata : rdata_q;

  assign bus.reg_strobe      = strobe;
  assign bus.data_out        = strobe ? pdata_q : 16'h0000;
  assign bus.reg_address_out = strobe ? preg_q : REG_NONE;
  assign bus.late_err        = late_q;

endmodule

// File: tb/tb_chipbus_slot_ctrl.sv
// Directed bench for chipbus_slot_ctrl.
// Post-buffer steps run when CHIPBUS_WRITE_POST_EN is defined.
module tb_chipbus_slot_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   nreq;
  int   nack;
  logic [1:0] we_log;
  int   base;

  chipbus_slot_ctrl_if #(.ADDR_W(20)) bus();

  chipbus_slot_ctrl #(
    .ADDR_W    (20),
    .SLOT_CLKS (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_req) begin
      nreq   = nreq + 1;
      we_log = {we_log[0], bus.mem_we};
    end
    if (bus.cpu_ack) nack = nack + 1;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    nreq   = 0;
    nack   = 0;
    we_log = 2'b00;
    reset  = 1'b1;
    bus.clk7_en = 0; bus.dbr = 0; bus.dbwe = 0;
    bus.dma_address = '0; bus.dma_reg_address = 8'hFF;
    bus.dma_wdata = '0; bus.cpu_custom = 0;
    bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_uds = 0; bus.cpu_lds = 0;
    bus.cpu_address = '0; bus.cpu_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;

    nxt(); nxt();
    smp();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_reg_addr", bus.reg_address_out, 8'hFF);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_late", bus.late_err, 0);
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    nxt();
    reset = 1'b0;
    nxt();

    // DMA read, ack on 2nd clk after mem_req, strobe next slot
    base = nreq;
    bus.clk7_en = 1; bus.dbr = 1; bus.dbwe = 0;
    bus.dma_address = 20'h01234;
    bus.dma_reg_address = 8'h88;
    smp(); chk("dma_req_lat0", bus.mem_req, 0);
    nxt();
    bus.clk7_en = 0; bus.dbr = 0;
    smp();
    chk("dma_req", bus.mem_req, 1);
    chk("dma_be", bus.mem_be, 2'b11);
    chk("dma_addr", bus.mem_address, 20'h01234);
    chk("dma_we", bus.mem_we, 0);
    nxt();
    smp(); chk("dma_req_once", bus.mem_req, 0);
    nxt();
    bus.mem_ack = 1; bus.mem_rdata = 16'hBEEF;
    smp(); chk("dma_no_early_strb", bus.reg_strobe, 0);
    nxt();
    bus.mem_ack = 0; bus.clk7_en = 1;
    smp();
    chk("dma_strobe", bus.reg_strobe, 1);
    chk("dma_data", bus.data_out, 16'hBEEF);
    chk("dma_reg", bus.reg_address_out, 8'h88);
    nxt();
    bus.clk7_en = 0;
    smp();
    chk("dma_strobe_end", bus.reg_strobe, 0);
    chk("dma_data_zero", bus.data_out, 0);
    chk("dma_nreq", nreq - base, 1);

`ifndef CHIPBUS_WRITE_POST_EN
    // CPU low-byte write
    nxt();
    base = nack;
    bus.clk7_en = 1; bus.cpu_custom = 1;
    bus.cpu_req = 1; bus.cpu_we = 1;
    bus.cpu_uds = 0; bus.cpu_lds = 1;
    bus.cpu_address = 20'h00100;
    bus.cpu_wdata = 16'h00AA;
    nxt();
    bus.clk7_en = 0;
    smp();
    chk("cw_req", bus.mem_req, 1);
    chk("cw_be", bus.mem_be, 2'b01);
    chk("cw_we", bus.mem_we, 1);
    chk("cw_wdata", bus.mem_wdata, 16'h00AA);
    nxt();
    bus.mem_ack = 1;
    smp(); chk("cw_ack", bus.cpu_ack, 1);
    nxt();
    bus.mem_ack = 0; bus.cpu_req = 0;
    smp(); chk("cw_ack_end", bus.cpu_ack, 0);
    nxt();
    bus.clk7_en = 1;
    nxt();
    bus.clk7_en = 0;
    smp();
    chk("cw_no_reissue", bus.mem_req, 0);
    chk("cw_nack", nack - base, 1);
`endif

    // DMA write wins over pending CPU read
    nxt();
    bus.clk7_en = 1; bus.dbr = 1; bus.dbwe = 1;
    bus.dma_address = 20'h00200;
    bus.dma_reg_address = 8'hFF;
    bus.dma_wdata = 16'h1111;
    bus.cpu_custom = 1; bus.cpu_req = 1;
    bus.cpu_we = 0; bus.cpu_uds = 1; bus.cpu_lds = 1;
    bus.cpu_address = 20'h00300;
    nxt();
    bus.clk7_en = 0; bus.dbr = 0;
    smp();
    chk("pri_dma_addr", bus.mem_address, 20'h00200);
    chk("pri_dma_we", bus.mem_we, 1);
    nxt();
    bus.mem_ack = 1;
    smp(); chk("pri_no_cpu_ack", bus.cpu_ack, 0);
    nxt();
    bus.mem_ack = 0;
    nxt();
    bus.clk7_en = 1;
    smp(); chk("pri_no_wr_strobe", bus.reg_strobe, 0);
    nxt();
    bus.clk7_en = 0;
    smp();
    chk("pri_cpu_req", bus.mem_req, 1);
    chk("pri_cpu_addr", bus.mem_address, 20'h00300);
    chk("pri_cpu_we", bus.mem_we, 0);
    nxt();
    bus.mem_ack = 1; bus.mem_rdata = 16'h5A5A;
    smp();
    chk("pri_cpu_ack", bus.cpu_ack, 1);
    chk("pri_rdata", bus.cpu_rdata, 16'h5A5A);
    nxt();
    bus.mem_ack = 0; bus.cpu_req = 0;
    smp(); chk("pri_rdata_hold", bus.cpu_rdata, 16'h5A5A);

    // Late ack: slot boundary during WAIT
    nxt();
    base = nreq;
    bus.cpu_custom = 0;
    bus.clk7_en = 1; bus.dbr = 1; bus.dbwe = 0;
    bus.dma_address = 20'h00400;
    bus.dma_reg_address = 8'h20;
    nxt();
    bus.clk7_en = 0;
    nxt(); nxt(); nxt();
    bus.clk7_en = 1;
    bus.dma_address = 20'h00444;
    nxt();
    bus.clk7_en = 0; bus.dbr = 0;
    smp();
    chk("late_err", bus.late_err, 1);
    chk("late_no_req", bus.mem_req, 0);
    nxt();
    bus.mem_ack = 1; bus.mem_rdata = 16'h1234;
    nxt();
    bus.mem_ack = 0; bus.clk7_en = 1;
    smp();
    chk("late_strobe", bus.reg_strobe, 1);
    chk("late_data", bus.data_out, 16'h1234);
    chk("late_reg", bus.reg_address_out, 8'h20);
    nxt();
    bus.clk7_en = 0;
    nxt();
    smp();
    chk("late_nreq", nreq - base, 1);
    chk("late_sticky", bus.late_err, 1);

    // Reset while waiting on a CPU read
    nxt();
    base = nack;
    bus.clk7_en = 1; bus.cpu_custom = 1;
    bus.cpu_req = 1; bus.cpu_we = 0;
    bus.cpu_address = 20'h00500;
    nxt();
    bus.clk7_en = 0;
    nxt();
    reset = 1;
    smp();
    chk("rw_mem_req", bus.mem_req, 0);
    chk("rw_late", bus.late_err, 0);
    chk("rw_reg_addr", bus.reg_address_out, 8'hFF);
    chk("rw_be", bus.mem_be, 0);
    nxt();
    reset = 0; bus.cpu_req = 0;
    bus.cpu_custom = 0;
    bus.mem_ack = 1; bus.mem_rdata = 16'hFFFF;
    smp();
    chk("rw_cpu_ack", bus.cpu_ack, 0);
    chk("rw_rdata", bus.cpu_rdata, 0);
    nxt();
    bus.mem_ack = 0;
    smp(); chk("rw_nack", nack - base, 0);

    // Ack coincident with slot boundary: back-to-back grant
    nxt();
    bus.clk7_en = 1; bus.dbr = 1; bus.dbwe = 0;
    bus.dma_address = 20'h00600;
    bus.dma_reg_address = 8'hFF;
    nxt();
    bus.clk7_en = 0;
    nxt(); nxt();
    bus.clk7_en = 1; bus.mem_ack = 1;
    bus.dma_address = 20'h00700;
    nxt();
    bus.clk7_en = 0; bus.mem_ack = 0; bus.dbr = 0;
    smp();
    chk("b2b_req", bus.mem_req, 1);
    chk("b2b_addr", bus.mem_address, 20'h00700);
    chk("b2b_not_late", bus.late_err, 0);
    nxt();
    bus.mem_ack = 1;
    nxt();
    bus.mem_ack = 0;

`ifdef CHIPBUS_WRITE_POST_EN
    // Posted write then read of the same word
    nxt();
    base = nack;
    bus.cpu_custom = 0; bus.cpu_req = 1;
    bus.cpu_we = 1; bus.cpu_uds = 1; bus.cpu_lds = 1;
    bus.cpu_address = 20'h00800;
    bus.cpu_wdata = 16'hCAFE;
    smp(); chk("pw_ack_lat0", bus.cpu_ack, 0);
    nxt();
    smp(); chk("pw_ack", bus.cpu_ack, 1);
    nxt();
    bus.cpu_req = 0;
    nxt();
    bus.cpu_req = 1; bus.cpu_we = 0;
    bus.clk7_en = 1; bus.cpu_custom = 1;
    nxt();
    bus.clk7_en = 0;
    smp();
    chk("pw_drain_we", bus.mem_we, 1);
    chk("pw_drain_data", bus.mem_wdata, 16'hCAFE);
    nxt();
    bus.mem_ack = 1;
    smp(); chk("pw_drain_no_ack", bus.cpu_ack, 0);
    nxt();
    bus.mem_ack = 0;
    nxt();
    bus.clk7_en = 1;
    nxt();
    bus.clk7_en = 0;
    smp(); chk("pr_we", bus.mem_we, 0);
    nxt();
    bus.mem_ack = 1; bus.mem_rdata = 16'hCAFE;
    smp();
    chk("pr_ack", bus.cpu_ack, 1);
    chk("pr_rdata", bus.cpu_rdata, 16'hCAFE);
    nxt();
    bus.mem_ack = 0; bus.cpu_req = 0;
    smp();
    chk("pw_order", we_log, 2'b10);
    chk("pw_nack", nack - base, 2);
`endif

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chipbus_slot_ctrl.md
# chipbus_slot_ctrl

Memory-side responder for the Agnus chip bus. Each 7 MHz bus slot it samples the slot owner (Agnus DMA when `dbr`, otherwise the CPU when `cpu_custom`), runs one chip RAM access with a req/ack handshake, and returns DMA read data to the custom-register bus with a register strobe one slot later. It sits between Agnus/Gary and the chip RAM controller (SDRAM arbiter port).

## Interface
Parameters:
- `ADDR_W`, 20: chip word address msb (address bits [ADDR_W:1]).
- `SLOT_CLKS`, 4: clk cycles per clk7_en slot. Used only for the late-ack check in the test plan; the RTL keys off `clk7_en`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clk7_en`  in  1  slot boundary strobe, one clk wide.
- `dbr`  in  1  Agnus owns this slot.
- `dbwe`  in  1  Agnus slot is a write (disk or blitter).
- `dma_address`  in  ADDR_W  Agnus chip address.
- `dma_reg_address`  in  8  Agnus register address [8:1]; 8'hFF means none.
- `dma_wdata`  in  16  chip data bus write data.
- `cpu_custom`  in  1  CPU may use this slot.
- `cpu_req`, `cpu_we`  in  1  CPU chip RAM request, which is level and held until `cpu_ack`; and its write flag.
- `cpu_uds`, `cpu_lds`  in  1  CPU byte enables (high byte, low byte).
- `cpu_address`  in  ADDR_W; `cpu_wdata`  in  16.
- `cpu_ack`  out  1  one-clk completion pulse; `cpu_rdata`  out  16.
- `mem_req`  out  1; `mem_we`  out  1; `mem_be`  out  2; `mem_address`  out  ADDR_W; `mem_wdata`  out  16.
- `mem_ack`  in  1  one-clk pulse; `mem_rdata`  in  16, valid with `mem_ack`.
- `data_out`  out  16  DMA read data toward the custom registers.
- `reg_address_out`  out  8  register address qualified by `reg_strobe`.
- `reg_strobe`  out  1  one-clk pulse.
- `late_err`  out  1  sticky; cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE → ISSUE on `clk7_en`:
  - if `dbr`: owner = DMA.
  - else if `cpu_custom & cpu_req` (and the CPU request has not already been serviced): owner = CPU.
  - otherwise the slot is unused and the FSM stays in IDLE.
- On the transition into ISSUE, latch address, write data, we, byte enables and register address.
  - DMA accesses use `mem_be`=2'b11.
  - CPU accesses use `mem_be`={uds,lds}.
- ISSUE: assert `mem_req` for exactly one clk, then go to WAIT. `mem_we`, `mem_be`, `mem_address` and `mem_wdata` are held stable until `mem_ack`.
- WAIT → IDLE on `mem_ack`, with these actions:
  - CPU: `cpu_ack` pulses the same clk; `cpu_rdata` = `mem_rdata` for reads and holds its value for writes.
  - DMA read with reg address ≠ 8'hFF: capture `mem_rdata`. At the next `clk7_en`, `data_out` and `reg_address_out` are driven and `reg_strobe` pulses for that clk.
  - DMA write: no strobe.
- `data_out` is 0 whenever no strobe is pending. This allows OR-muxing onto the chip data bus.
- Late ack, i.e. `clk7_en` arrives while in ISSUE or WAIT:
  - the new slot is dropped and never queued;
  - `late_err` is set;
  - the current access continues to completion.
  - A dropped CPU slot is retried in the next eligible slot. A dropped DMA slot is lost.
- Simultaneous `clk7_en` and `mem_ack` in WAIT: the access completes, and the new slot is sampled in that same clk (WAIT → ISSUE directly). This is not a late case.
- `mem_ack` in IDLE is ignored.

## Timing
- Reset values: all outputs 0, except `reg_address_out`=8'hFF. FSM is IDLE. No pending strobe.
- `mem_req` rises 1 clk after `clk7_en`.
- Minimum `cpu_ack` latency: 2 clk after the `clk7_en` that grants the slot (`mem_ack` on the first WAIT clk).
- DMA read data is strobed exactly at the next `clk7_en`. That is one slot later, matching the register-bus pipeline.
- Reset asserted mid-access: all state clears asynchronously, the outstanding `mem_ack` is ignored, and no `cpu_ack` is issued.

## Configuration
- `CHIPBUS_WRITE_POST_EN` defined:
  - adds a one-entry CPU write buffer. A CPU write gets `cpu_ack` 1 clk after `cpu_req` if the buffer is empty, and drains in the next CPU-owned slot.
  - CPU reads with a full buffer wait until it drains, so write-then-read ordering is preserved.
  - A write request while the buffer is full waits for the drain.
- Undefined: CPU writes are synchronous exactly as above, with no buffer logic.

## Structure
- Package `chipbus_pkg`: FSM state enum, owner enum (NONE/DMA/CPU), `REG_NONE`=8'hFF.
- One sub-module, `chipbus_wbuf`: the posting buffer (valid flag, address, data, byte enables). It is instantiated only under `CHIPBUS_WRITE_POST_EN`.

## Test plan
- DMA read: `dbr`=1, address 20'h01234, reg 8'h88, `mem_ack` with 16'hBEEF on the 2nd clk after `mem_req`. Expect `mem_req`/`mem_be`=2'b11, then at the next `clk7_en` a `reg_strobe` with `data_out`=16'hBEEF and `reg_address_out`=8'h88.
- CPU byte write: `cpu_custom`=1, `cpu_we`=1, `lds` only, data 16'h00AA. Expect `mem_be`=2'b01, `mem_we`=1, and a single `cpu_ack` pulse.
- DMA priority: `dbr`=1 with `cpu_req` pending. Expect the DMA access first; the CPU access is served in the next slot where `dbr`=0.
- Late ack: hold `mem_ack` off for 6 clk across a `clk7_en` with `dbr`=1. Expect `late_err`=1, the second slot dropped, and exactly one `mem_req`.
- Reset during WAIT, then `mem_ack`. Expect no `cpu_ack` and all outputs at their reset values.
- With `CHIPBUS_WRITE_POST_EN`: a CPU write followed by a read to the same address. Expect the write acked in 1 clk, and `mem_req` order write then read.
